// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Watches a multiplexed, active-low 7-segment display bus (segments plus digit
// anodes) and rebuilds the 8-digit hexadecimal number being shown. A digit is
// taken only after its (anode, segment) pair has been stable for STABLE_CYCLES
// samples, which rejects ghosting while the scanner switches digits. Once all
// eight digits have been seen, the frame is published on value with a
// one-cycle frame_valid pulse.
module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4  // legal range 2..255
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic [6:0]  out7,         // {g,f,e,d,c,b,a}, active-low
  input  logic [7:0]  en_out,       // digit anodes, active-low, bit i = digit i
  input  logic        clear_err,
  output logic [31:0] value,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        err_seg,
  output logic        err_anode
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] EN_BLANK   = 8'hFF;

  // Result of looking a segment pattern up in the hex font.
  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } decode_t;

  // Map an active-low segment pattern to its hex digit; ok is low for any
  // pattern that is not one of the sixteen glyphs.
  function automatic decode_t decode_seg(input logic [6:0] seg);
    decode_t d;
    d.ok  = 1'b1;
    d.nib = 4'h0;
    case (seg)
      7'h40:   d.nib = 4'h0;
      7'h79:   d.nib = 4'h1;
      7'h24:   d.nib = 4'h2;
      7'h30:   d.nib = 4'h3;
      7'h19:   d.nib = 4'h4;
      7'h12:   d.nib = 4'h5;
      7'h02:   d.nib = 4'h6;
      7'h78:   d.nib = 4'h7;
      7'h00:   d.nib = 4'h8;
      7'h10:   d.nib = 4'h9;
      7'h08:   d.nib = 4'hA;
      7'h03:   d.nib = 4'hB;
      7'h46:   d.nib = 4'hC;
      7'h21:   d.nib = 4'hD;
      7'h06:   d.nib = 4'hE;
      7'h0E:   d.nib = 4'hF;
      default: d.ok  = 1'b0;
    endcase
    return d;
  endfunction

  // Input sample and the sample before it; every decision uses these copies.
  logic [6:0]  seg_q;
  logic [7:0]  en_q;
  logic [6:0]  seg_prev_q;
  logic [7:0]  en_prev_q;

  // Dwell tracking.
  logic [7:0]  stab_cnt_q;
  logic [7:0]  stab_cnt_d;
  logic        accepted_q;
  logic        accepted_d;

  // Frame assembly.
  logic [31:0] stage_q;
  logic [31:0] stage_d;
  logic [7:0]  seen_q;
  logic [7:0]  seen_d;

  // Next values of the registered outputs.
  logic [31:0] value_d;
  logic        frame_valid_d;
  logic [7:0]  frame_count_d;
  logic        err_seg_d;
  logic        err_anode_d;

  // Per-edge decisions.
  logic        same_pair;
  logic [7:0]  digit_mask;
  logic        one_digit;
  logic        multi_digit;
  decode_t     dec;
  logic        fire;
  logic        capture;

  // The anode bus is active-low, so the inverted copy has a 1 for each
  // enabled digit. Exactly one bit set means a real digit; none is a blank.
  assign same_pair   = (seg_q == seg_prev_q) && (en_q == en_prev_q);
  assign digit_mask  = ~en_q;
  assign one_digit   = (digit_mask != 8'd0) && ((digit_mask & (digit_mask - 8'd1)) == 8'd0);
  assign multi_digit = (digit_mask != 8'd0) && !one_digit;
  assign dec         = decode_seg(seg_q);

  // Register the raw bus once and keep the previous sample for comparison.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q      <= SEG_BLANK;
      en_q       <= EN_BLANK;
      seg_prev_q <= SEG_BLANK;
      en_prev_q  <= EN_BLANK;
    end else begin
      // NOTE: non-blocking assignments let seg_prev_q take the old seg_q in
      // the same edge; blocking ones would make both copies equal.
      seg_q      <= out7;
      en_q       <= en_out;
      seg_prev_q <= seg_q;
      en_prev_q  <= en_q;
    end
  end

  // Stability counting, acceptance, digit staging, frame publishing and the
  // sticky error flags.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    stab_cnt_d    = 8'd1;
    accepted_d    = 1'b0;
    fire          = 1'b0;
    capture       = 1'b0;
    stage_d       = stage_q;
    seen_d        = seen_q;
    value_d       = value;
    frame_valid_d = 1'b0;
    frame_count_d = frame_count;
    err_seg_d     = err_seg & ~clear_err;
    err_anode_d   = err_anode & ~clear_err;

    // A changed pair restarts the dwell at 1 and re-arms acceptance; an
    // unchanged pair counts up to STABLE_MAX and fires once on arrival there.
    if (same_pair) begin
      stab_cnt_d = (stab_cnt_q >= STABLE_MAX) ? STABLE_MAX : (stab_cnt_q + 8'd1);
      fire       = (stab_cnt_d == STABLE_MAX) && !accepted_q;
      accepted_d = accepted_q | fire;
    end

    // A detected error on this edge beats a simultaneous clear_err.
    if (fire && multi_digit) begin
      err_anode_d = 1'b1;
    end
    if (fire && one_digit && !dec.ok) begin
      err_seg_d = 1'b1;
    end

    // Blank (no anode) dwells fall through with no effect at all.
    capture = fire && one_digit && dec.ok;
    if (capture) begin
      for (int i = 0; i < 8; i++) begin
        if (digit_mask[i]) begin
          stage_d[4*i +: 4] = dec.nib;
        end
      end
      seen_d = seen_q | digit_mask;
      // The digit that completes the set is already merged into stage_d, so
      // the published value includes it.
      if (seen_d == 8'hFF) begin
        value_d       = stage_d;
        frame_valid_d = 1'b1;
        frame_count_d = frame_count + 8'd1;
        seen_d        = 8'd0;
      end
    end
  end

  // State register for the dwell tracker, the frame assembly and the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_cnt_q  <= 8'd0;
      accepted_q  <= 1'b0;
      // NOTE: the staging register and seen bits are reset along with the
      // outputs so a partially captured frame never survives a reset.
      stage_q     <= 32'd0;
      seen_q      <= 8'd0;
      value       <= 32'd0;
      frame_valid <= 1'b0;
      frame_count <= 8'd0;
      err_seg     <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      stab_cnt_q  <= stab_cnt_d;
      accepted_q  <= accepted_d;
      stage_q     <= stage_d;
      seen_q      <= seen_d;
      value       <= value_d;
      frame_valid <= frame_valid_d;
      frame_count <= frame_count_d;
      err_seg     <= err_seg_d;
      err_anode   <= err_anode_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Testbench for seg7_scan_capture. Stimulus is a sequence of held
// (en_out, out7) pairs. A dwell-level reference model predicts each accepted
// digit, the sticky error flags and every completed frame (value, count and
// the cycle its frame_valid pulse must appear in); frames go into a queue that
// an independent monitor drains whenever frame_valid is high.
module tb_seg7_scan_capture;

  localparam int S = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [6:0]  out7      = 7'h7F;
  logic [7:0]  en_out    = 8'hFF;
  logic        clear_err = 1'b0;
  logic [31:0] value;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        err_seg;
  logic        err_anode;

  seg7_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .out7        (out7),
    .en_out      (en_out),
    .clear_err   (clear_err),
    .value       (value),
    .frame_valid (frame_valid),
    .frame_count (frame_count),
    .err_seg     (err_seg),
    .err_anode   (err_anode)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;   // number of rising edges so far
  int pulses = 0;   // frame_valid pulses seen by the monitor

  always @(posedge clk) cyc <= cyc + 1;

  // Hex font, index = digit value.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [31:0] value;
    logic [7:0]  count;
    int          at;
  } frame_t;

  frame_t exp_q[$];

  // Reference model state.
  logic [3:0]  m_nib [8];
  logic [7:0]  m_seen;
  logic [31:0] m_value;
  logic [7:0]  m_count;
  bit          m_err_seg;
  bit          m_err_anode;
  logic [7:0]  m_en;
  logic [6:0]  m_seg;
  int          m_start;
  int          m_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit lookup(input logic [6:0] seg, output logic [3:0] nib);
    bit hit = 1'b0;
    nib = 4'h0;
    for (int h = 0; h < 16; h++) begin
      if (seg_tab[h] == seg) begin
        hit = 1'b1;
        nib = 4'(h);
      end
    end
    return hit;
  endfunction

  function automatic logic [7:0] dig(input int d);
    return ~(8'd1 << d);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    m_seen      = 8'd0;
    m_value     = 32'd0;
    m_count     = 8'd0;
    m_err_seg   = 1'b0;
    m_err_anode = 1'b0;
    m_en        = 8'hFF;
    m_seg       = 7'h7F;
    m_start     = 0;
    m_len       = S;
  endtask

  // A dwell of (en, seg) is accepted; apply its effect, publishing a frame
  // whose pulse is due in the cycle numbered 'at'.
  task automatic model_accept(input logic [7:0] en, input logic [6:0] seg, input int at);
    logic [7:0]  mask;
    logic [3:0]  nib;
    logic [31:0] v;
    int          idx;
    mask = ~en;
    if (mask == 8'd0) return;
    if ($countones(mask) > 1) begin
      m_err_anode = 1'b1;
      return;
    end
    idx = 0;
    for (int i = 0; i < 8; i++) if (mask[i]) idx = i;
    if (!lookup(seg, nib)) begin
      m_err_seg = 1'b1;
      return;
    end
    m_nib[idx]  = nib;
    m_seen[idx] = 1'b1;
    if (&m_seen) begin
      v = 32'd0;
      for (int i = 0; i < 8; i++) v |= 32'(m_nib[i]) << (4 * i);
      m_value = v;
      m_count = m_count + 8'd1;
      m_seen  = 8'd0;
      exp_q.push_back('{v, m_count, at});
    end
  endtask

  // A pair is presented for n edges starting at edge k. Consecutive identical
  // pairs form one dwell; a dwell of at least S edges starting at edge k is
  // accepted on edge k+S, once.
  task automatic model_present(input logic [7:0] en, input logic [6:0] seg, input int n, input int k);
    int prev;
    if (en == m_en && seg == m_seg) begin
      prev  = m_len;
      m_len = m_len + n;
      if (prev < S && m_len >= S) model_accept(en, seg, m_start + S);
    end else begin
      m_en    = en;
      m_seg   = seg;
      m_start = k;
      m_len   = n;
      if (n >= S) model_accept(en, seg, k + S);
    end
  endtask

  // Called at a falling edge; holds the pair for n rising edges.
  task automatic hold(input logic [7:0] en, input logic [6:0] seg, input int n);
    model_present(en, seg, n, cyc + 1);
    en_out = en;
    out7   = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    hold(8'hFF, 7'h7F, S + 3);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_value"}, value, m_value);
    check({tag, "_count"}, 32'(frame_count), 32'(m_count));
    check({tag, "_err_seg"}, 32'(err_seg), 32'(m_err_seg));
    check({tag, "_err_anode"}, 32'(err_anode), 32'(m_err_anode));
    check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_errs(input string tag);
    clear_err   = 1'b1;
    m_err_seg   = 1'b0;
    m_err_anode = 1'b0;
    @(negedge clk);
    clear_err = 1'b0;
    check({tag, "_err_seg"}, 32'(err_seg), 32'd0);
    check({tag, "_err_anode"}, 32'(err_anode), 32'd0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    en_out = 8'hFF;
    out7   = 7'h7F;
    reset  = 1'b0;
    #1;
    check({tag, "_rst_value"}, value, 32'd0);
    check({tag, "_rst_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_rst_count"}, 32'(frame_count), 32'd0);
    check({tag, "_rst_err_seg"}, 32'(err_seg), 32'd0);
    check({tag, "_rst_err_anode"}, 32'(err_anode), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every frame_valid pulse must match the next expected frame.
  frame_t got;
  always @(negedge clk) begin
    if (reset === 1'b1 && frame_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: frame_valid high with value %h, none expected (cycle %0d)", value, cyc);
      end else begin
        got = exp_q.pop_front();
        check("frame_value", value, got.value);
        check("frame_count", 32'(frame_count), 32'(got.count));
        check("frame_cycle", 32'(cyc), 32'(got.at));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          p0;
  int          kind;
  int          d;
  logic [7:0]  r_en;
  logic [6:0]  r_seg;
  logic [3:0]  r_nib;
  int          order [8];
  int          j;
  int          tmp;

  initial begin
    model_reset();
    #1;
    do_reset("por");
    idle();

    // Scan 7..0 showing 1..8.
    p0 = pulses;
    for (int k = 7; k >= 0; k--) hold(dig(k), seg_tab[8 - k], S);
    idle();
    check("scan_value", value, 32'h12345678);
    check("scan_count", 32'(frame_count), 32'd1);
    check("scan_pulses", 32'(pulses - p0), 32'd1);
    check_quiet("scan");

    // Digit 0 held one cycle too short: no frame until it is shown properly.
    p0 = pulses;
    hold(dig(0), seg_tab[9], S - 1);
    for (int k = 1; k < 8; k++) hold(dig(k), seg_tab[10], S);
    idle();
    check("short_pulses", 32'(pulses - p0), 32'd0);
    check("short_value", value, 32'h12345678);
    hold(dig(0), seg_tab[12], S);
    idle();
    check("short_done_value", value, 32'hAAAAAAAC);
    check("short_done_pulses", 32'(pulses - p0), 32'd1);

    // Error handling with digits 7..1 already staged.
    p0 = pulses;
    for (int k = 7; k >= 1; k--) hold(dig(k), seg_tab[5], S);
    hold(8'hFE, 7'h7F, S);
    idle();
    check("bad_seg_flag", 32'(err_seg), 32'd1);
    check_quiet("bad_seg");
    clear_errs("clr1");
    hold(8'hFC, seg_tab[2], S);
    idle();
    check("multi_flag", 32'(err_anode), 32'd1);
    check_quiet("multi");

    // clear_err on the very edge a new segment error is detected.
    model_present(8'hFE, 7'h7F, S + 2, cyc + 1);
    en_out = 8'hFE;
    out7   = 7'h7F;
    repeat (S) @(negedge clk);
    clear_err   = 1'b1;
    m_err_anode = 1'b0;
    @(negedge clk);
    clear_err = 1'b0;
    check("race_err_seg", 32'(err_seg), 32'd1);
    check("race_err_anode", 32'(err_anode), 32'd0);
    @(negedge clk);
    clear_errs("clr2");
    hold(8'hFF, seg_tab[1], 20);
    check_quiet("blank");
    check("blank_pulses", 32'(pulses - p0), 32'd0);
    hold(dig(0), seg_tab[3], S);
    idle();
    check("err_done_value", value, 32'h55555553);
    check("err_done_pulses", 32'(pulses - p0), 32'd1);

    // Reset with a partial frame staged, then a full scan of F.
    for (int k = 7; k >= 3; k--) hold(dig(k), seg_tab[9], S);
    idle();
    do_reset("mid");
    p0 = pulses;
    for (int k = 0; k < 8; k++) hold(dig(k), seg_tab[15], S);
    idle();
    check("mid_value", value, 32'hFFFFFFFF);
    check("mid_count", 32'(frame_count), 32'd1);
    check("mid_pulses", 32'(pulses - p0), 32'd1);
    check_quiet("mid");

    // 256 random frames in shuffled digit order: the count wraps to 0.
    do_reset("wrap");
    p0 = pulses;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 8; k++) order[k] = k;
      for (int k = 7; k > 0; k--) begin
        j        = $urandom_range(0, k);
        tmp      = order[k];
        order[k] = order[j];
        order[j] = tmp;
      end
      for (int k = 0; k < 8; k++) begin
        r_nib = 4'($urandom_range(0, 15));
        hold(dig(order[k]), seg_tab[r_nib], $urandom_range(S, S + 2));
      end
      hold(8'hFF, 7'h7F, 1);
    end
    idle();
    check("wrap_count", 32'(frame_count), 32'd0);
    check("wrap_pulses", 32'(pulses - p0), 32'd256);
    check_quiet("wrap");

    // Mixed random traffic: legal, illegal, multi-anode and blank dwells of
    // random length, repeats and any order.
    for (int it = 0; it < 1500; it++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom_range(0, 7);
      if (kind < 7) begin
        r_en  = dig(d);
        r_nib = 4'($urandom_range(0, 15));
        r_seg = seg_tab[r_nib];
      end else if (kind == 7) begin
        r_en  = dig(d);
        r_seg = 7'($urandom);
        while (lookup(r_seg, r_nib)) r_seg = 7'($urandom);
      end else if (kind == 8) begin
        r_en = 8'($urandom);
        while ($countones(~r_en) < 2) r_en = 8'($urandom);
        r_seg = 7'($urandom);
      end else begin
        r_en  = 8'hFF;
        r_seg = 7'($urandom);
      end
      hold(r_en, r_seg, $urandom_range(1, S + 2));
    end
    idle();
    check_quiet("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
